// File: rtl/countdown_audio_core.sv
// rtl/countdown_audio_core.sv - countdown timebase dividers, alarm beeper and melody player on one buzzer pin
//
// Purpose: two 50%-duty clock dividers (fast_clk, slow_clk) for the countdown logic,
// a fixed-pitch alarm tone and a 16-step background melody, muxed onto audio_out.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   beep_en   in   1 = alarm tone on audio_out (overrides the melody)
//   music_en  in   1 = melody plays; 0 = melody held at step 0, silent
//   fast_clk  out  square wave, period 2*FAST_DIV clk cycles
//   slow_clk  out  square wave, period 2*SLOW_DIV clk cycles
//   audio_out out  registered buzzer drive: beep_en ? beep_wave : music_wave
//
// Configuration macro: MUSIC_LOOP_EN
//   defined   - melody wraps from step 15 back to step 0 while music_en=1
//   undefined - melody plays once, then stays silent until music_en drops or rst

module countdown_audio_core #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int FAST_DIV    = 500_000,
    parameter int SLOW_DIV    = 50_000_000,
    parameter int BEEP_HZ     = 1000,
    parameter int NOTE_CYCLES = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic beep_en,
    input  logic music_en,
    output logic fast_clk,
    output logic slow_clk,
    output logic audio_out
);

    localparam int FW = $clog2(FAST_DIV + 1);
    localparam int SW = $clog2(SLOW_DIV + 1);
    localparam int NW = $clog2(NOTE_CYCLES + 1);

    localparam int BEEP_H = CLK_HZ / (2 * BEEP_HZ);
    localparam int BW     = $clog2(BEEP_H + 1);

    // E4 is the lowest note, so it has the longest half-period and sizes the tone counter.
    localparam int H_E4 = CLK_HZ / (2 * 330);
    localparam int TW   = $clog2(H_E4 + 1);

    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);
    localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYCLES - 1);
    localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_H - 1);

    localparam logic [TW-1:0] HALF_E4 = TW'(H_E4);
    localparam logic [TW-1:0] HALF_G4 = TW'(CLK_HZ / (2 * 392));
    localparam logic [TW-1:0] HALF_A4 = TW'(CLK_HZ / (2 * 440));
    localparam logic [TW-1:0] HALF_C5 = TW'(CLK_HZ / (2 * 523));
    localparam logic [TW-1:0] HALF_D5 = TW'(CLK_HZ / (2 * 587));
    localparam logic [TW-1:0] HALF_REST = '0;

    // Melody ROM: half-period per step, zero marks a rest.
    function automatic logic [TW-1:0] note_half(input logic [3:0] s);
        case (s)
            4'd0, 4'd1, 4'd8, 4'd9, 4'd11: note_half = HALF_G4;
            4'd2, 4'd6, 4'd12, 4'd13:      note_half = HALF_A4;
            4'd3, 4'd5, 4'd7:              note_half = HALF_C5;
            4'd4:                          note_half = HALF_D5;
            4'd10:                         note_half = HALF_E4;
            default:                       note_half = HALF_REST;
        endcase
    endfunction

    // ---------------- timebase dividers ----------------
    logic [FW-1:0] fast_cnt;
    logic [SW-1:0] slow_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            fast_cnt <= '0;
            fast_clk <= 1'b0;
        end else if (fast_cnt == FAST_LAST) begin
            fast_cnt <= '0;
            fast_clk <= ~fast_clk;
        end else begin
            fast_cnt <= fast_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slow_cnt <= '0;
            slow_clk <= 1'b0;
        end else if (slow_cnt == SLOW_LAST) begin
            slow_cnt <= '0;
            slow_clk <= ~slow_clk;
        end else begin
            slow_cnt <= slow_cnt + 1'b1;
        end
    end

    // ---------------- alarm beeper ----------------
    logic [BW-1:0] beep_cnt;
    logic          beep_wave;

    always_ff @(posedge clk) begin
        if (rst || !beep_en) begin
            beep_cnt  <= '0;
            beep_wave <= 1'b0;
        end else if (beep_cnt == BEEP_LAST) begin
            beep_cnt  <= '0;
            beep_wave <= ~beep_wave;
        end else begin
            beep_cnt <= beep_cnt + 1'b1;
        end
    end

    // ---------------- melody player ----------------
    logic [3:0]    step;
    logic [NW-1:0] dur_cnt;
    logic [TW-1:0] tone_cnt;
    logic          music_wave;
    logic          done;
    logic [TW-1:0] cur_half;

    assign cur_half = note_half(step);

    always_ff @(posedge clk) begin
        if (rst || !music_en) begin
            step       <= '0;
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            music_wave <= 1'b0;
            done       <= 1'b0;
        end else if (done) begin
            tone_cnt   <= '0;
            music_wave <= 1'b0;
        end else if (dur_cnt == NOTE_LAST) begin
            // Step boundary: the new note always starts from a low phase.
            dur_cnt    <= '0;
            tone_cnt   <= '0;
            music_wave <= 1'b0;
`ifdef MUSIC_LOOP_EN
            step <= step + 1'b1;
`else
            if (step == 4'd15) begin
                done <= 1'b1;
            end else begin
                step <= step + 1'b1;
            end
`endif
        end else begin
            dur_cnt <= dur_cnt + 1'b1;
            if (cur_half == HALF_REST) begin
                tone_cnt   <= '0;
                music_wave <= 1'b0;
            end else if (tone_cnt == cur_half - 1'b1) begin
                tone_cnt   <= '0;
                music_wave <= ~music_wave;
            end else begin
                tone_cnt <= tone_cnt + 1'b1;
            end
        end
    end

    // ---------------- output mux ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            audio_out <= 1'b0;
        end else begin
            audio_out <= beep_en ? beep_wave : music_wave;
        end
    end

endmodule

// File: tb/tb_countdown_audio_core.sv
// tb/tb_countdown_audio_core.sv - randomized bench for countdown_audio_core against a count-based reference model

module tb_countdown_audio_core;

    localparam int CLK_HZ      = 100_000;
    localparam int FAST_DIV    = 5;
    localparam int SLOW_DIV    = 50;
    localparam int BEEP_HZ     = 1000;
    localparam int NOTE_CYCLES = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic beep_en = 1'b0;
    logic music_en = 1'b0;
    logic fast_clk, slow_clk, audio_out;

    countdown_audio_core #(
        .CLK_HZ(CLK_HZ), .FAST_DIV(FAST_DIV), .SLOW_DIV(SLOW_DIV),
        .BEEP_HZ(BEEP_HZ), .NOTE_CYCLES(NOTE_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .beep_en(beep_en), .music_en(music_en),
        .fast_clk(fast_clk), .slow_clk(slow_clk), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference state: edges since reset release, enabled-melody edges, enabled-beep edges.
    int m_edges = 0;
    int k_music = 0;
    int b_beep  = 0;
    int exp_audio = 0;

    int freq [16] = '{392, 392, 440, 523, 587, 523, 440, 523,
                      392, 392, 330, 392, 440, 440, 0, 0};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int square(input int edges, input int half);
        return (edges / half) % 2;
    endfunction

    // Melody level after kk enabled edges: each step lasts NOTE_CYCLES edges and its
    // tone restarts low at the boundary edge.
    function automatic int music_level(input int kk);
        int s, j, idx;
        s = kk / NOTE_CYCLES;
        j = kk - s * NOTE_CYCLES;
`ifndef MUSIC_LOOP_EN
        if (s >= 16) return 0;
`endif
        idx = s % 16;
        if (freq[idx] == 0) return 0;
        return square(j, CLK_HZ / (2 * freq[idx]));
    endfunction

    function automatic int beep_level(input int bb);
        return square(bb, CLK_HZ / (2 * BEEP_HZ));
    endfunction

    // Apply one set of inputs for one clock edge, advance the model, compare outputs.
    task automatic cycle(input logic r, input logic be, input logic me);
        rst = r;
        beep_en = be;
        music_en = me;
        @(posedge clk);
        if (r) begin
            m_edges = 0;
            k_music = 0;
            b_beep = 0;
            exp_audio = 0;
        end else begin
            exp_audio = be ? beep_level(b_beep) : music_level(k_music);
            m_edges++;
            b_beep  = be ? b_beep + 1 : 0;
            k_music = me ? k_music + 1 : 0;
        end
        #1;
        cyc++;
        check_eq("audio_out", audio_out, exp_audio);
        check_eq("fast_clk", fast_clk, square(m_edges, FAST_DIV));
        check_eq("slow_clk", slow_clk, square(m_edges, SLOW_DIV));
        @(negedge clk);
    endtask

    initial begin
        int len;
        logic be, me;
        @(negedge clk);

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

        // Beeper alone, then release.
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0);

        // Melody with random beep bursts on top.
        while (k_music < 8000 || k_music == 0) begin
            len = $urandom_range(50, 400);
            be = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < len; i++) cycle(1'b0, be, 1'b1);
        end

        // Run into step 5, then reset in the middle of it with music still enabled.
        while (k_music < 5 * NOTE_CYCLES + 700) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1);

        // Full sequence plus margin to exercise wrap or done.
        for (int i = 0; i < 16 * NOTE_CYCLES + 3000; i++) cycle(1'b0, 1'b0, 1'b1);

        // Drop music_en briefly: melody must restart from step 0.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3000; i++) cycle(1'b0, 1'b0, 1'b1);

        // Fully random segments over both enables.
        for (int seg = 0; seg < 20; seg++) begin
            len = $urandom_range(20, 300);
            be = $urandom_range(0, 1) != 0;
            me = $urandom_range(0, 3) != 0;
            for (int i = 0; i < len; i++) cycle(1'b0, be, me);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
